// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] CSUM_INIT      = 8'h00;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte strobe.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             rx_s1_q, rx_s2_q;
  rx_state_e        rx_st_q, rx_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [1:0]       flush_q, flush_d;
  logic             armed_q, armed_d;
  logic             bv_q, bv_d;
  logic             fe_q, fe_d;

  assign byte_valid = bv_q;
  assign byte_data  = sh_q;
  assign frame_err  = fe_q;

  // Bit-timing state machine; armed_q means the line has been seen idle-high since reset or a bad stop bit.
  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    armed_d = armed_q;
    flush_d = flush_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    if (flush_q != 2'd2) flush_d = flush_q + 2'd1;
    case (rx_st_q)
      RX_IDLE: begin
        if (armed_q && !rx_s2_q) begin
          rx_st_d = RX_START;
          cnt_d   = ONE;
          armed_d = 1'b0;
        end else if (flush_q == 2'd2 && rx_s2_q) begin
          armed_d = 1'b1;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          if (!rx_s2_q) begin
            rx_st_d = RX_DATA;
            cnt_d   = ONE;
            bit_d   = 3'd0;
          end else begin
            rx_st_d = RX_IDLE;
            armed_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          cnt_d = ONE;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          rx_st_d = RX_IDLE;
          if (rx_s2_q) begin
            bv_d    = 1'b1;
            armed_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Synchroniser and receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      flush_q <= '0;
      armed_q <= 1'b0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a LEN/DATA/CSUM framed image over UART and writes it into instruction memory.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              skip,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int         CNT_W = ADDR_W + 1;
  localparam logic [8:0] CAP   = 9'(1 << ADDR_W);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [23:0]      wbuf_q, wbuf_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] wl_q, wl_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  assign imem_we      = we_q;
  assign imem_addr    = wl_q[ADDR_W-1:0];
  assign imem_wdata   = wdata_q;
  assign core_hold    = hold_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = wl_q;

  // Frame parser: word assembly, checksum, and write sequencing. The word count advances
  // during the write cycle so imem_addr still shows the slot being written.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    wl_d    = wl_q;
    if (we_q) wl_d = wl_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: state_d = skip ? ST_DONE : ST_LEN;
      ST_LEN: begin
        if (frame_err) begin
          state_d = ST_ERR;
        end else if (byte_valid) begin
          acc_d = CSUM_INIT;
          if (byte_data == 8'd0) begin
            state_d = ST_CSUM;
          end else if ({1'b0, byte_data} > CAP) begin
            state_d = ST_ERR;
          end else begin
            len_d   = CNT_W'(byte_data);
            idx_d   = 2'd0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (frame_err) begin
          state_d = ST_ERR;
        end else if (byte_valid) begin
          acc_d = acc_q ^ byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
            we_d    = 1'b1;
            wdata_d = {byte_data, wbuf_q};
          end else begin
            wbuf_d[idx_q*8 +: 8] = byte_data;
          end
        end else if (we_q && wl_d == len_q) begin
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (frame_err) begin
          state_d = ST_ERR;
        end else if (byte_valid) begin
          state_d = (byte_data == acc_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = state_q;
    endcase
    hold_d = (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  // Loader FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= CSUM_INIT;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wl_q    <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wl_q    <= wl_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: frame-level reference model, write monitor, final-state checks.
module tb_uart_imem_loader;

  localparam int C  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          skip = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  uart_imem_loader #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .skip         (skip),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write, and last only one cycle.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && imem_we) begin
      if (prev_we) begin
        checks++;
        errors++;
        $display("FAIL we_width: got strobe on consecutive cycles, expected one-cycle pulse");
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
      end
    end
    prev_we = imem_we && !rst;
  end

  // Reference model of a whole frame: derives writes and the final flags from the framing rules.
  task automatic model_frame(input logic [7:0] fr[$], input int bad,
                             output logic e_done, output logic e_err, output int e_words);
    int n;
    logic [7:0] acc;
    logic [31:0] w;
    wr_t wr;
    e_done = 1'b0; e_err = 1'b0; e_words = 0; acc = 8'h00; w = '0;
    if (bad == 0) begin e_err = 1'b1; return; end
    n = int'(fr[0]);
    if (n > (1 << AW)) begin e_err = 1'b1; return; end
    for (int i = 0; i < 4 * n; i++) begin
      if (bad == 1 + i) begin e_err = 1'b1; return; end
      acc ^= fr[1+i];
      w[8*(i%4) +: 8] = fr[1+i];
      if (i % 4 == 3) begin
        wr.addr = AW'(e_words);
        wr.data = w;
        exp_q.push_back(wr);
        e_words++;
      end
    end
    if (bad == 1 + 4 * n) begin e_err = 1'b1; return; end
    if (fr[1+4*n] == acc) e_done = 1'b1; else e_err = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk);
    rst = 1'b1; rx = 1'b1; skip = s;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input int bad, input int gap);
    logic e_done, e_err;
    int e_words;
    model_frame(fr, bad, e_done, e_err, e_words);
    repeat (4) @(negedge clk);
    for (int k = 0; k < fr.size(); k++) begin
      send_byte(fr[k], (k != bad));
      if (k == bad) break;
      repeat (gap) @(negedge clk);
    end
    for (int i = 0; i < 200; i++) begin
      if (done || error) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_err));
    chk("core_hold", 32'(core_hold), 32'(!e_done));
    chk("words_loaded", 32'(words_loaded), 32'(e_words));
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] acc;
    logic [7:0] d;
    int n, bad;

    // Reset values
    do_reset(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    // Skip path
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    chk("skip_done", 32'(done), 32'd1);
    chk("skip_hold", 32'(core_hold), 32'd0);
    chk("skip_words", 32'(words_loaded), 32'd0);

    // Two-word frame, good checksum
    do_reset(1'b0);
    fr = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_frame(fr, -1, 0);

    // Same frame, bad checksum
    do_reset(1'b0);
    fr = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    run_frame(fr, -1, 0);

    // Length beyond capacity
    do_reset(1'b0);
    fr = '{8'h41};
    run_frame(fr, -1, 0);

    // Framing error on second data byte
    do_reset(1'b0);
    fr = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_frame(fr, 2, 0);

    // One-cycle glitch while waiting for LEN, then a valid frame
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_done", 32'(done), 32'd0);
    chk("glitch_error", 32'(error), 32'd0);
    chk("glitch_hold", 32'(core_hold), 32'd1);
    fr = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame(fr, -1, 1);

    // Reset mid-word, then a clean one-word frame
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    do_reset(1'b0);
    fr = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run_frame(fr, -1, 0);

    // Randomized frames
    for (int it = 0; it < 10; it++) begin
      do_reset(1'b0);
      fr.delete();
      bad = -1;
      if (it == 3) begin
        fr.push_back(8'($urandom_range(65, 255)));
      end else begin
        n = int'($urandom_range(1, 5));
        fr.push_back(8'(n));
        acc = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          d = 8'($urandom);
          acc ^= d;
          fr.push_back(d);
        end
        fr.push_back(($urandom_range(0, 2) == 0) ? (acc ^ 8'h5A) : acc);
        if ($urandom_range(0, 3) == 0) bad = int'($urandom_range(1, 4 * n + 1));
      end
      run_frame(fr, bad, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
